sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 The module SHALL have parameter REF_PERIOD, default 390, meaning clk_50m cycles between refresh requests (7.8 us at 50 MHz).
REQ-002 The module SHALL have parameter ADDR_W, default 24, meaning command address width {bank[1:0], row[12:0], col[8:0]}.
REQ-003 The module SHALL have parameter LEN_W, default 9, meaning burst length width in 16-bit words.
REQ-004 clk_50m  in  1  sole clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 init_done  in  1  controller power-up sequence complete; level.
REQ-007 wr_req  in  1  write requester request; held until wr_ack.
REQ-008 wr_addr, wr_len  in  ADDR_W, LEN_W  write start address and length; stable while wr_req=1.
REQ-009 wr_ack, wr_done  out  1, 1  grant pulse; completion pulse.
REQ-010 rd_req, rd_addr, rd_len, rd_ack, rd_done  same as write port, read side.
REQ-011 cmd_valid  out  1  command offered to SDRAM controller.
REQ-012 cmd_op  out  2  00 refresh, 01 write, 10 read; 11 never driven.
REQ-013 cmd_addr, cmd_len  out  ADDR_W, LEN_W  command parameters; 0 for refresh.
REQ-014 cmd_ready  in  1  controller accepts when cmd_valid & cmd_ready.
REQ-015 cmd_done  in  1  one-cycle pulse when accepted command finishes.
REQ-016 ref_ovf  out  1  sticky: refresh backlog overflowed.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT; at most one command outstanding.
REQ-018 IDLE: while init_done=0, SHALL stay IDLE and grant nothing.
REQ-019 IDLE with init_done=1: priority SHALL be refresh (ref_pend>0), then wr/rd round-robin; registered choice, next state ISSUE.
REQ-020 Round-robin: if both wr_req and rd_req, grant the port not granted last; last_grant updates only on wr/rd grants, not refresh.
REQ-021 Entering ISSUE SHALL latch cmd_op/cmd_addr/cmd_len and assert cmd_valid; request in IDLE at cycle N -> cmd_valid at N+1.
REQ-022 ISSUE: cmd_valid and payload SHALL hold stable until cmd_ready=1; in the handshake cycle wr_ack/rd_ack pulses one cycle (none for refresh); next cycle cmd_valid=0, state WAIT.
REQ-023 WAIT: on cmd_done SHALL pulse wr_done/rd_done one cycle later (registered); refresh decrements ref_pend; return to IDLE.
REQ-024 cmd_done outside WAIT SHALL be ignored.
REQ-025 Refresh timer: counter held 0 while init_done=0; else counts 0..REF_PERIOD-1 and wraps; each wrap increments ref_pend.
REQ-026 ref_pend SHALL be 2 bits, saturating at 3; increment at 3 sets ref_ovf; simultaneous increment and decrement leaves ref_pend unchanged.
REQ-027 ref_ovf SHALL clear only on reset.
REQ-028 Requests arriving in ISSUE/WAIT SHALL wait; no preemption of a granted command.
REQ-029 init_done falling mid-operation SHALL not abort the current command; new grants stop at IDLE.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, all outputs 0, ref_pend 0, timer 0, ref_ovf 0, last_grant=read (so write wins first tie).
REQ-031 Reset asserted in ISSUE or WAIT SHALL drop cmd_valid immediately; no ack/done pulses follow.

Verification (REF_PERIOD=16 for scenarios 1-5)
REQ-032 init_done=0, wr_req=1 for 50 cycles -> cmd_valid stays 0; timer stays 0.
REQ-033 init_done=1, wr_req=rd_req=1 continuously, cmd_ready=1, cmd_done 3 cycles after accept -> grants alternate W,R,W,R; each ack one cycle; cmd_op 01/10 matches.
REQ-034 wr_req with wr_addr=24'h12_3456, wr_len=256, cmd_ready low 5 cycles -> cmd_valid/cmd_addr/cmd_len stable 5 cycles, wr_ack in cycle cmd_ready rises, wr_done 1 cycle after cmd_done.
REQ-035 Timer wrap while read outstanding and wr_req pending -> after read done, refresh (cmd_op=00, addr 0, len 0) issued before write.
REQ-036 cmd_ready=0 for 70 cycles after init_done -> ref_pend saturates at 3, ref_ovf=1 at 4th wrap and stays 1 after backlog drains.
REQ-037 Default REF_PERIOD, idle 1200 cycles after init_done -> exactly 3 refresh commands, spaced 390 cycles.

Source files
------------

// File: rtl/sdram_arb_if.sv
// sdram_arb_if: requester ports and controller command channel
// bundled for the SDRAM arbiter.
interface sdram_arb_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9
);
    logic              init_done;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_ack;
    logic              wr_done;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_ack;
    logic              rd_done;

    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ready;
    logic              cmd_done;

    logic              ref_ovf;

    modport slave (
        input  init_done,
        input  wr_req, wr_addr, wr_len,
        input  rd_req, rd_addr, rd_len,
        input  cmd_ready, cmd_done,
        output wr_ack, wr_done,
        output rd_ack, rd_done,
        output cmd_valid, cmd_op, cmd_addr, cmd_len,
        output ref_ovf
    );

    modport master (
        output init_done,
        output wr_req, wr_addr, wr_len,
        output rd_req, rd_addr, rd_len,
        output cmd_ready, cmd_done,
        input  wr_ack, wr_done,
        input  rd_ack, rd_done,
        input  cmd_valid, cmd_op, cmd_addr, cmd_len,
        input  ref_ovf
    );
endinterface

// File: rtl/sdram_arb.sv
// sdram_arb: one-outstanding-command arbiter between refresh,
// a write port and a read port in front of an SDRAM controller.
module sdram_arb #(
    parameter int REF_PERIOD = 390,
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 9
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    sdram_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] OP_REF = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam int         TW     = $clog2(REF_PERIOD + 1);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              valid_q, valid_d;
    logic              last_wr_q, last_wr_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [1:0]        pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              wrap;
    logic              ref_dec;
    logic              hs;
    logic              wr_win;

    assign hs     = (state_q == ISSUE) && bus.cmd_ready;
    assign wrap   = bus.init_done && (tmr_q == TW'(REF_PERIOD - 1));
    // Write wins unless a read also waits and the last grant was a write.
    assign wr_win = bus.wr_req && (!bus.rd_req || !last_wr_q);

    assign bus.cmd_valid = valid_q;
    assign bus.cmd_op    = op_q;
    assign bus.cmd_addr  = addr_q;
    assign bus.cmd_len   = len_q;
    assign bus.wr_ack    = hs && (op_q == OP_WR);
    assign bus.rd_ack    = hs && (op_q == OP_RD);
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.ref_ovf   = ovf_q;

    // Refresh interval timer; frozen at zero until the controller is up.
    always_comb begin
        tmr_d = tmr_q;
        if (!bus.init_done || wrap) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    // Refresh backlog: saturating count, sticky overflow flag.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (wrap && !ref_dec) begin
            if (pend_q == 2'd3) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (ref_dec && !wrap) begin
            pend_d = pend_q - 2'd1;
        end
    end

    // Arbitration FSM: next state, latched command and done pulses.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        len_d     = len_q;
        valid_d   = valid_q;
        last_wr_d = last_wr_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        ref_dec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (bus.init_done) begin
                    priority case (1'b1)
                        (pend_q != 2'd0): begin
                            op_d    = OP_REF;
                            addr_d  = '0;
                            len_d   = '0;
                            valid_d = 1'b1;
                            state_d = ISSUE;
                        end
                        wr_win: begin
                            op_d      = OP_WR;
                            addr_d    = bus.wr_addr;
                            len_d     = bus.wr_len;
                            valid_d   = 1'b1;
                            last_wr_d = 1'b1;
                            state_d   = ISSUE;
                        end
                        bus.rd_req: begin
                            op_d      = OP_RD;
                            addr_d    = bus.rd_addr;
                            len_d     = bus.rd_len;
                            valid_d   = 1'b1;
                            last_wr_d = 1'b0;
                            state_d   = ISSUE;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (bus.cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.cmd_done) begin
                    wr_done_d = (op_q == OP_WR);
                    rd_done_d = (op_q == OP_RD);
                    ref_dec   = (op_q == OP_REF);
                    state_d   = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves read as last grant.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            addr_q    <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
            last_wr_q <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            tmr_q     <= '0;
            pend_q    <= 2'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
            last_wr_q <= last_wr_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            tmr_q     <= tmr_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed scenarios for sdram_arb with a command
// scoreboard popped by a monitor on every cmd handshake.
module tb_sdram_arb;
    localparam int AW = 24;
    localparam int LW = 9;
    localparam logic [1:0] OP_REF = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_left  = 0;
    int rd_left  = 0;
    int ref_cnt  = 0;
    bit allow_ref = 1'b0;
    logic done_prev = 1'b0;
    cmd_t exp_q[$];
    logic [1:0] done_q[$];
    int t2_q[$];
    cmd_t mon_e;
    logic [1:0] mon_d;

    sdram_arb_if #(.ADDR_W(AW), .LEN_W(LW)) b ();
    sdram_arb_if #(.ADDR_W(AW), .LEN_W(LW)) b2 ();

    sdram_arb #(.REF_PERIOD(16), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk_50m(clk),
        .rst_n  (rst_n),
        .bus    (b)
    );

    sdram_arb #(.ADDR_W(AW), .LEN_W(LW)) dut2 (
        .clk_50m(clk),
        .rst_n  (rst_n),
        .bus    (b2)
    );

    always #10 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic void push_cmd(input logic [1:0] op,
                                     input logic [AW-1:0] a,
                                     input logic [LW-1:0] l);
        exp_q.push_back('{op: op, addr: a, len: l});
        if (op != OP_REF) done_q.push_back(op);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_left = 0;
        rd_left = 0;
        allow_ref = 1'b0;
        b.init_done = 1'b0;
        b.cmd_ready = 1'b1;
        b2.init_done = 1'b0;
        exp_q.delete();
        done_q.delete();
        repeat (3) tick();
        chk("reset_outs", {b.cmd_valid, b.wr_ack, b.rd_ack, b.wr_done,
            b.rd_done, b.ref_ovf, b.cmd_op, b.cmd_addr, b.cmd_len}, 64'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size() + done_q.size(), 0);
        repeat (2) tick();
    endtask

    // requesters: hold req until the matching ack is seen
    initial forever begin
        @(negedge clk);
        if (b.wr_ack && wr_left > 0) wr_left--;
        if (b.rd_ack && rd_left > 0) rd_left--;
        b.wr_req = (wr_left > 0);
        b.rd_req = (rd_left > 0);
    end

    // controller model: cmd_done 3 cycles after accept
    initial forever begin
        @(negedge clk);
        if (rst_n && b.cmd_valid && b.cmd_ready) begin
            repeat (3) @(posedge clk);
            #2 b.cmd_done = 1'b1;
            @(posedge clk);
            #2 b.cmd_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && b2.cmd_valid && b2.cmd_ready) begin
            repeat (2) @(posedge clk);
            #2 b2.cmd_done = 1'b1;
            @(posedge clk);
            #2 b2.cmd_done = 1'b0;
        end
    end

    // monitor: scoreboard pop on handshakes and done pulses
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (b.cmd_valid && b.cmd_ready) begin
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("cmd_op", b.cmd_op, mon_e.op);
                    chk("cmd_addr", b.cmd_addr, mon_e.addr);
                    chk("cmd_len", b.cmd_len, mon_e.len);
                    chk("wr_ack", b.wr_ack, mon_e.op == OP_WR);
                    chk("rd_ack", b.rd_ack, mon_e.op == OP_RD);
                end else if (allow_ref) begin
                    ref_cnt++;
                    chk("ref_cmd", {b.cmd_op, b.cmd_addr, b.cmd_len,
                        b.wr_ack, b.rd_ack}, 64'd0);
                end else begin
                    chk("unexpected_cmd", b.cmd_op, 2'b11);
                end
            end else begin
                chk("stray_ack", {b.wr_ack, b.rd_ack}, 2'b00);
            end
            if (b.wr_done || b.rd_done) begin
                chk("done_latency", done_prev, 1'b1);
                if (done_q.size() != 0) begin
                    mon_d = done_q.pop_front();
                    chk("done_kind", {b.wr_done, b.rd_done},
                        (mon_d == OP_WR) ? 2'b10 : 2'b01);
                end else begin
                    chk("unexpected_done", {b.wr_done, b.rd_done}, 2'b00);
                end
            end
        end
        done_prev = b.cmd_done;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && b2.cmd_valid && b2.cmd_ready) begin
            t2_q.push_back(cyc);
            chk("ref2_cmd", {b2.cmd_op, b2.cmd_addr, b2.cmd_len}, 64'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int start;
        b.init_done = 1'b0;
        b.wr_req = 1'b0; b.wr_addr = '0; b.wr_len = '0;
        b.rd_req = 1'b0; b.rd_addr = '0; b.rd_len = '0;
        b.cmd_ready = 1'b1; b.cmd_done = 1'b0;
        b2.init_done = 1'b0;
        b2.wr_req = 1'b0; b2.wr_addr = '0; b2.wr_len = '0;
        b2.rd_req = 1'b0; b2.rd_addr = '0; b2.rd_len = '0;
        b2.cmd_ready = 1'b1; b2.cmd_done = 1'b0;
        do_reset();

        // no grants and frozen timer while init_done is low
        b.wr_addr = 24'h00_0040;
        b.wr_len = 9'd4;
        wr_left = 1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (b.cmd_valid) bad++;
        end
        chk("noinit_valid", bad, 0);
        wr_left = 0;
        tick();
        push_cmd(OP_REF, '0, '0);
        b.init_done = 1'b1;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (b.cmd_valid) n = i;
        end
        chk("first_ref_cycle", n, 18);
        drain();
        do_reset();

        // round robin with both ports busy
        b.wr_addr = 24'h00_1200; b.wr_len = 9'd8;
        b.rd_addr = 24'h21_0040; b.rd_len = 9'd16;
        push_cmd(OP_WR, 24'h00_1200, 9'd8);
        push_cmd(OP_RD, 24'h21_0040, 9'd16);
        push_cmd(OP_WR, 24'h00_1200, 9'd8);
        push_cmd(OP_RD, 24'h21_0040, 9'd16);
        push_cmd(OP_REF, '0, '0);
        wr_left = 2;
        rd_left = 2;
        b.init_done = 1'b1;
        drain();
        do_reset();

        // controller stall holds the command payload
        b.cmd_ready = 1'b0;
        b.wr_addr = 24'h12_3456;
        b.wr_len = 9'd256;
        push_cmd(OP_WR, 24'h12_3456, 9'd256);
        push_cmd(OP_REF, '0, '0);
        wr_left = 1;
        b.init_done = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", {b.cmd_valid, b.cmd_op, b.cmd_addr, b.cmd_len},
                {1'b1, OP_WR, 24'h12_3456, 9'd256});
        end
        b.cmd_ready = 1'b1;
        drain();
        do_reset();

        // refresh due during a read beats the waiting write
        b.wr_addr = 24'h05_0505; b.wr_len = 9'd2;
        b.rd_addr = 24'h0A_0A0A; b.rd_len = 9'd3;
        push_cmd(OP_RD, 24'h0A_0A0A, 9'd3);
        push_cmd(OP_REF, '0, '0);
        push_cmd(OP_WR, 24'h05_0505, 9'd2);
        b.init_done = 1'b1;
        repeat (12) tick();
        rd_left = 1;
        tick();
        wr_left = 1;
        drain();
        do_reset();

        // reset during ISSUE drops cmd_valid at once
        b.cmd_ready = 1'b0;
        b.rd_addr = 24'h00_0777; b.rd_len = 9'd1;
        rd_left = 1;
        b.init_done = 1'b1;
        repeat (2) tick();
        chk("issue_valid", b.cmd_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", b.cmd_valid, 1'b0);
        do_reset();
        repeat (4) tick();

        // refresh backlog saturation and sticky overflow
        b.cmd_ready = 1'b0;
        allow_ref = 1'b1;
        b.init_done = 1'b1;
        repeat (50) tick();
        chk("ovf_before", b.ref_ovf, 1'b0);
        repeat (20) tick();
        chk("ovf_set", b.ref_ovf, 1'b1);
        ref_cnt = 0;
        b.cmd_ready = 1'b1;
        repeat (16) tick();
        chk("backlog_drain", ref_cnt >= 3, 1'b1);
        repeat (40) tick();
        chk("ovf_sticky", b.ref_ovf, 1'b1);
        do_reset();

        // default period: three refreshes in 1200 idle cycles
        t2_q.delete();
        start = cyc;
        b2.init_done = 1'b1;
        repeat (1200) tick();
        chk("ref2_count", t2_q.size(), 3);
        if (t2_q.size() == 3) begin
            chk("ref2_first", t2_q[0] - start, 391);
            chk("ref2_gap1", t2_q[1] - t2_q[0], 390);
            chk("ref2_gap2", t2_q[2] - t2_q[1], 390);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
